// File: rtl/soi_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soi_trace_pkg
// Brief    : Shared types and constants for the SOI change-detect trace stage
// Revision : 1.0 - initial release
// ============================================================================
package soi_trace_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRIME   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Width of the dropped-entry counter
    localparam int OVF_W = 16;

    // Width of one FIFO entry {ts, value}. The entry struct itself is declared
    // inside the modules that use it, because its field widths are parameters.
    function automatic int entry_w(input int ts_w, input int value_w);
        return ts_w + value_w;
    endfunction

    // Saturating increment for the overflow counter
    function automatic logic [OVF_W-1:0] sat_inc(input logic [OVF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soi_trace_if.sv
`default_nettype none
// ============================================================================
// Module   : soi_trace_if
// Brief    : valid/ready read port carrying timestamped SOI entries
// Revision : 1.0 - initial release
// ============================================================================
interface soi_trace_if #(
    parameter int WIDTH = 1,
    parameter int TS_W  = 32
);
    logic             rd_valid;
    logic             rd_ready;
    logic [TS_W-1:0]  rd_ts;
    logic [WIDTH-1:0] rd_value;

    // Trace stage drives the entry, consumer drives ready
    modport master (output rd_valid, rd_ts, rd_value, input rd_ready);
    modport slave  (input rd_valid, rd_ts, rd_value, output rd_ready);
endinterface
`default_nettype wire

// File: rtl/soi_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : soi_trace_fifo
// Brief    : Synchronous show-ahead FIFO with push/pop/level and sync clear
// Revision : 1.0 - initial release
// ============================================================================
module soi_trace_fifo #(
    parameter int EW    = 33,
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   clear_i,
    input  wire logic                   push_i,
    input  wire logic [EW-1:0]          data_i,
    input  wire logic                   pop_i,
    output logic      [EW-1:0]          head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic      [$clog2(DEPTH):0] level_o
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          w_pop, w_push;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    // Head is zero while empty so the read port shows clean reset values
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // When full, a push is only accepted if the head leaves in the same cycle
    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    // Entry storage; no reset needed since the head is gated by empty
    always_ff @(posedge clk) begin
        if (w_push && !clear_i)
            mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers and occupancy; clear discards any push/pop of the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (w_push && !w_pop)      level_q <= level_q + 1'b1;
            else if (!w_push && w_pop) level_q <= level_q - 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/soi_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : soi_trace_capture
// Brief    : Change-detect SOI tracer: timestamps every value change and
//            queues it for a valid/ready consumer
// Revision : 1.0 - initial release
// ============================================================================
module soi_trace_capture
    import soi_trace_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int TS_W  = 32,
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   enable,
    input  wire logic                   clear,
    input  wire logic [WIDTH-1:0]       soi_in,
    soi_trace_if.master                 rd,
    output logic      [$clog2(DEPTH):0] level,
    output logic      [OVF_W-1:0]       overflow_cnt,
    output logic                        capturing
);
    localparam int EW = entry_w(TS_W, WIDTH);

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [WIDTH-1:0] value;
    } entry_t;

    state_t           state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             w_push, w_full, w_empty;
    entry_t           w_push_entry, w_head;

    assign w_push_entry = '{ts: ts_q, value: soi_in};

    // Controller, timestamp and change detector; clear overrides everything
    always_comb begin
        state_d = state_q;
        ts_d    = ts_q;
        prev_d  = prev_q;
        w_push  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_PRIME;
                    ts_d    = '0;
                end
            end
            ST_PRIME: begin
                // Baseline entry always goes in, even if enable just dropped
                w_push  = 1'b1;
                prev_d  = soi_in;
                ts_d    = ts_q + 1'b1;
                state_d = enable ? ST_CAPTURE : ST_IDLE;
            end
            ST_CAPTURE: begin
                if (soi_in != prev_q) begin
                    w_push = 1'b1;
                    prev_d = soi_in;
                end
                if (enable) ts_d    = ts_q + 1'b1;
                else        state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d = ST_IDLE;
            ts_d    = '0;
            prev_d  = '0;
            w_push  = 1'b0;
        end
    end

    // A push into a full FIFO is dropped unless the consumer pops that cycle
    always_comb begin
        ovf_d = ovf_q;
        if (clear)
            ovf_d = '0;
        else if (w_push && w_full && !rd.rd_ready)
            ovf_d = sat_inc(ovf_q);
    end

    // State, timestamp, previous value and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            prev_q  <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_d;
            prev_q  <= prev_d;
            ovf_q   <= ovf_d;
        end
    end

    soi_trace_fifo #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (rd.rd_ready),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level)
    );

    assign rd.rd_valid   = ~w_empty;
    assign rd.rd_ts      = w_head.ts;
    assign rd.rd_value   = w_head.value;
    assign overflow_cnt  = ovf_q;
    assign capturing     = (state_q == ST_CAPTURE);
endmodule
`default_nettype wire
